// File: rtl/arbiter_requester_if.sv
// Handshake bundle between one round-robin arbiter port's requester agent and its environment.
// master is the requester agent's view; slave is the job source / arbiter side.
interface arbiter_requester_if #(
    parameter int LEN_W = 4
);
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             req;
    logic             gnt;
    logic             beat;
    logic             last;
    logic             busy;
    logic             starve_err;

    modport master (
        input  job_valid, job_len, gnt,
        output job_ready, req, beat, last, busy, starve_err
    );

    modport slave (
        output job_valid, job_len, gnt,
        input  job_ready, req, beat, last, busy, starve_err
    );
endinterface

// File: rtl/arbiter_requester.sv
// Requester agent for one port of a 3-way round-robin arbiter: queues jobs, requests, counts granted beats.
// Optional macro WAIT_TIMEOUT_EN adds a sticky starvation flag for long waits in REQ.
module arbiter_requester #(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    arbiter_requester_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (MAX_WAIT >= (1 << WAIT_W))) begin : g_cfg_err
        $error("arbiter_requester: illegal parameter combination");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [REM_W-1:0] remaining_r;
    logic [REM_W-1:0] remaining_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             beat_s;

    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_r == CNT_W'(0));
    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push_s  = bus.job_valid & ~full_s;

    // Job queue storage and write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {LEN_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bus.job_len;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state, pop and beat decode.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        pop_s           = 1'b0;
        beat_s          = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s           = 1'b1;
                    remaining_nxt_s = {1'b0, mem_r[rd_ptr_r]} + REM_W'(1);
                    state_nxt_s     = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ, S_XFER: begin
                if (bus.gnt) begin
                    beat_s          = 1'b1;
                    remaining_nxt_s = remaining_r - REM_W'(1);
                    if (remaining_r == REM_W'(1)) begin
                        state_nxt_s = S_RELEASE;
                    end else begin
                        state_nxt_s = S_XFER;
                    end
                end else begin
                    // Losing the grant mid-job falls back to REQ with the beat count kept.
                    state_nxt_s = S_REQ;
                end
            end
            S_RELEASE: state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // State and remaining-beat registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            remaining_r <= {REM_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    assign bus.job_ready = ~full_s;
    assign bus.req       = (state_r == S_REQ) | (state_r == S_XFER);
    assign bus.beat      = beat_s;
    assign bus.last      = beat_s & (remaining_r == REM_W'(1));
    assign bus.busy      = (state_r != S_IDLE) | ~empty_s;

`ifdef WAIT_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              starve_r;

    // Wait counter for ungranted REQ cycles and sticky starvation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            starve_r   <= 1'b0;
        end else begin
            if (pop_s || ((state_r == S_XFER) && !bus.gnt)) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if ((state_r == S_REQ) && !bus.gnt && (wait_cnt_r != {WAIT_W{1'b1}})) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r == S_REQ) && !bus.gnt && (wait_cnt_r >= WAIT_W'(MAX_WAIT))) begin
                starve_r <= 1'b1;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

    assign bus.starve_err = starve_r;
`else
    assign bus.starve_err = 1'b0;
`endif
endmodule

// File: tb/tb_arbiter_requester.sv
// Directed, table-driven bench for arbiter_requester: per-cycle vectors plus queue-full,
// starvation and asynchronous-reset sequences.
module tb_arbiter_requester;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

`ifdef WAIT_TIMEOUT_EN
    localparam logic STARVE_EXP = 1'b1;
`else
    localparam logic STARVE_EXP = 1'b0;
`endif

    arbiter_requester_if #(.LEN_W(4)) bus ();

    arbiter_requester #(
        .LEN_W(4), .FIFO_DEPTH(4), .MAX_WAIT(15), .WAIT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       jv;
        logic [3:0] jl;
        logic       g;
        logic [4:0] exp;   // {req, beat, last, job_ready, busy}
    } vec_t;

    vec_t vt[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are read 1 time unit later.
    task automatic step(input logic jv, input logic [3:0] jl, input logic g);
        @(negedge clk);
        bus.job_valid = jv;
        bus.job_len   = jl;
        bus.gnt       = g;
        #1;
    endtask

    logic [4:0] outs;
    int         lens[5];
    int         q[$];
    int         cnt;
    int         accepted;
    int         nbeats;

    initial begin
        checks = 0;
        errors = 0;
        // single job, gnt follows req one cycle late
        vt[0]  = '{1'b1, 4'd2, 1'b0, 5'b00010};
        vt[1]  = '{1'b0, 4'd0, 1'b0, 5'b00011};
        vt[2]  = '{1'b0, 4'd0, 1'b0, 5'b10011};
        vt[3]  = '{1'b0, 4'd0, 1'b1, 5'b11011};
        vt[4]  = '{1'b0, 4'd0, 1'b1, 5'b11011};
        vt[5]  = '{1'b0, 4'd0, 1'b1, 5'b11111};
        vt[6]  = '{1'b0, 4'd0, 1'b1, 5'b00011};
        vt[7]  = '{1'b0, 4'd0, 1'b0, 5'b00010};
        vt[8]  = '{1'b0, 4'd0, 1'b0, 5'b00010};
        // preemption: gnt 1,1,0,0,0,1,1 on a 4-beat job
        vt[9]  = '{1'b1, 4'd3, 1'b0, 5'b00010};
        vt[10] = '{1'b0, 4'd0, 1'b0, 5'b00011};
        vt[11] = '{1'b0, 4'd0, 1'b1, 5'b11011};
        vt[12] = '{1'b0, 4'd0, 1'b1, 5'b11011};
        vt[13] = '{1'b0, 4'd0, 1'b0, 5'b10011};
        vt[14] = '{1'b0, 4'd0, 1'b0, 5'b10011};
        vt[15] = '{1'b0, 4'd0, 1'b0, 5'b10011};
        vt[16] = '{1'b0, 4'd0, 1'b1, 5'b11011};
        vt[17] = '{1'b0, 4'd0, 1'b1, 5'b11111};
        vt[18] = '{1'b0, 4'd0, 1'b1, 5'b00011};
        vt[19] = '{1'b0, 4'd0, 1'b0, 5'b00010};
        // back-to-back single-beat jobs, gnt held high
        vt[20] = '{1'b1, 4'd0, 1'b1, 5'b00010};
        vt[21] = '{1'b1, 4'd0, 1'b1, 5'b00011};
        vt[22] = '{1'b0, 4'd0, 1'b1, 5'b11111};
        vt[23] = '{1'b0, 4'd0, 1'b1, 5'b00011};
        vt[24] = '{1'b0, 4'd0, 1'b1, 5'b00011};
        vt[25] = '{1'b0, 4'd0, 1'b1, 5'b11111};
        vt[26] = '{1'b0, 4'd0, 1'b1, 5'b00011};
        vt[27] = '{1'b0, 4'd0, 1'b1, 5'b00010};

        bus.job_valid = 1'b0;
        bus.job_len   = 4'd0;
        bus.gnt       = 1'b0;
        reset         = 1'b0;
        #7;
        check("reset_outs", {27'd0, bus.req, bus.beat, bus.last, bus.job_ready, bus.busy}, 32'b00010);
        check("reset_starve", {31'd0, bus.starve_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(vt[i].jv, vt[i].jl, vt[i].g);
            outs = {bus.req, bus.beat, bus.last, bus.job_ready, bus.busy};
            check($sformatf("vec%0d", i), {27'd0, outs}, {27'd0, vt[i].exp});
        end

        // Queue full: gnt low, six pushes, five accepted (one moves into REQ).
        lens = '{1, 0, 2, 1, 3};
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 5) ? lens[i][3:0] : 4'd7, 1'b0);
            check($sformatf("full_ready%0d", i), {31'd0, bus.job_ready}, (i < 5) ? 32'd1 : 32'd0);
            if (bus.job_ready) accepted++;
        end
        check("full_accepted", accepted, 32'd5);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step(1'b0, 4'd0, 1'b1);
            if (bus.beat) begin
                cnt++;
                if (bus.last) begin
                    q.push_back(cnt);
                    cnt = 0;
                end
            end
        end
        check("full_jobs", q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_len%0d", i), (i < q.size()) ? q[i] : -1, lens[i] + 1);
        end
        check("full_tail", cnt, 32'd0);
        check("full_idle", {31'd0, bus.busy}, 32'd0);

        // Starvation: one job waits 16 ungranted REQ cycles.
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            step(1'b0, 4'd0, 1'b0);
            if (c == 1)  check("starve_req", {31'd0, bus.req}, 32'd1);
            if (c == 16) check("starve_c16", {31'd0, bus.starve_err}, 32'd0);
            if (c == 17) check("starve_c17", {31'd0, bus.starve_err}, {31'd0, STARVE_EXP});
        end
        step(1'b0, 4'd0, 1'b1);
        check("starve_beat", {30'd0, bus.beat, bus.last}, 32'b11);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        check("starve_sticky", {31'd0, bus.starve_err}, {31'd0, STARVE_EXP});
        check("starve_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a transfer with another job queued.
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        check("rst_pre", {30'd0, bus.req, bus.beat}, 32'b11);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async", {26'd0, bus.req, bus.beat, bus.last, bus.job_ready, bus.busy, bus.starve_err},
              32'b000100);
        @(negedge clk);
        reset = 1'b1;
        nbeats = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 4'd0, 1'b1);
            if (bus.beat) nbeats++;
        end
        check("rst_nobeats", nbeats, 32'd0);
        check("rst_empty", {30'd0, bus.busy, bus.job_ready}, 32'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
